// File: rtl/eluks_pkg.sv
// eluks_pkg: shared constants for the ELUKS Wishbone slave.
//   - register window offsets (byte offsets from BASE_ADDR)
//   - FSM state encoding (3-bit constants, exposed on the debug port)
//   - status word layout: error flag in the MSB, total block count below it
package eluks_pkg;

  // Register window offsets
  localparam logic [2:0] ELUKS_PSW_0       = 3'd0;
  localparam logic [2:0] ELUKS_PSW_1       = 3'd1;
  localparam logic [2:0] ELUKS_START_BLOCK = 3'd2;
  localparam logic [2:0] ELUKS_BLOCK_DIR   = 3'd3;
  localparam logic [2:0] ELUKS_HMAC_ENABLE = 3'd4;
  localparam logic [2:0] ELUKS_RQ_DATA     = 3'd5;
  localparam logic [2:0] ELUKS_RQ_STATUS   = 3'd6;
  localparam int         ELUKS_NUM_REGS    = 7;

  // FSM state encoding
  typedef logic [2:0] eluks_state_t;
  localparam eluks_state_t S_IDLE      = 3'd0;
  localparam eluks_state_t S_ACK       = 3'd1;
  localparam eluks_state_t S_WAIT_CORE = 3'd2;
  localparam eluks_state_t S_WAIT_BYTE = 3'd3;
  localparam eluks_state_t S_RELEASE   = 3'd4;

  // Status word layout
  localparam int STATUS_W       = 32;
  localparam int STATUS_ERR_BIT = STATUS_W - 1;
  localparam int STATUS_CNT_W   = STATUS_W - 1;

  function automatic logic [STATUS_W-1:0] pack_status(input logic err,
                                                      input logic [STATUS_CNT_W-1:0] cnt);
    logic [STATUS_W-1:0] w;
    w                     = '0;
    w[STATUS_ERR_BIT]     = err;
    w[STATUS_CNT_W-1:0]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/eluks_wb_slave_if.sv
// eluks_wb_slave_if: Wishbone classic bus between the bootloader master and
// the ELUKS slave.
//   master modport: drives adr/dat_i/sel/we/cyc/stb, receives dat_o/ack/err
//   slave modport : the reverse
// Handshake: a request is valid while cyc & stb are high; the slave answers
// with a one-cycle ack and read data valid in that same cycle. The master
// keeps the request stable until it sees ack, then drops stb (and cyc) before
// issuing the next request.
interface eluks_wb_slave_if #(
  parameter int WB_DATA = 32
);
  logic [WB_DATA-1:0]   wb_adr_i;
  logic [WB_DATA-1:0]   wb_dat_i;
  logic [WB_DATA/8-1:0] wb_sel_i;
  logic                 wb_we_i;
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic [WB_DATA-1:0]   wb_dat_o;
  logic                 wb_ack_o;
  logic                 wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/eluks_byte_fifo.sv
// eluks_byte_fifo: synchronous FIFO of 9-bit entries ({last, byte}).
// Ports: clk, rst (sync, active-high), flush (empties, wins over push),
//        push/wr_data, pop/rd_data (first-word fall-through), full, empty.
// A push and a pop in the same cycle leave the count unchanged, even when
// full (the popped slot is reused) or empty (the pushed entry passes
// straight through to rd_data).
module eluks_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [8:0] wr_data,
  input  logic       pop,
  output logic [8:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop  && (!empty || push);
  assign do_push = push && (!full  || pop);
  assign rd_data = empty ? wr_data : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eluks_wb_slave.sv
// eluks_wb_slave: Wishbone slave front-end of the ELUKS decryption core.
// Ports:
//   wb_clk, rst          clock, synchronous active-high reset
//   wb                   Wishbone classic slave (eluks_wb_slave_if.slave)
//   psw, start_block,    configuration registers driven to the core
//   block_dir, hmac_enable
//   core_start           one-cycle start pulse on an RQ_STATUS write
//   core_done/error/     completion pulse and status from the core
//   core_total_blocks
//   byte_valid/data/last plaintext byte stream; byte_ready = FIFO not full
//   dbg_state            current FSM state
// Byte stream: a byte is transferred on every edge where byte_valid and
// byte_ready are both high; the core holds a byte while byte_ready is low.
module eluks_wb_slave
  import eluks_pkg::*;
#(
  parameter int                 WB_DATA    = 32,
  parameter logic [WB_DATA-1:0] BASE_ADDR  = 32'h9200_0000,
  parameter int                 FIFO_DEPTH = 16
) (
  input  logic                   wb_clk,
  input  logic                   rst,
  eluks_wb_slave_if.slave        wb,
  output logic [63:0]            psw,
  output logic [31:0]            start_block,
  output logic [31:0]            block_dir,
  output logic                   hmac_enable,
  output logic                   core_start,
  input  logic                   core_done,
  input  logic                   core_error,
  input  logic [STATUS_CNT_W-1:0] core_total_blocks,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   byte_last,
  output logic                   byte_ready,
  output eluks_state_t           dbg_state
);

  eluks_state_t         state;
  logic [31:0]          psw_0, psw_1, start_block_q, block_dir_q, hmac_q;
  logic [STATUS_W-1:0]  status;
  logic                 drained;
  logic [WB_DATA-1:0]   dat_o;

  logic [WB_DATA-1:0]   offset;
  logic                 in_win;
  logic [2:0]           off_idx;
  logic                 req;
  logic [31:0]          wdat;

  logic                 fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [8:0]           fifo_rd;
  logic                 core_done_ok;

  eluks_state_t         idle_next;
  logic [WB_DATA-1:0]   idle_word;

  logic                 unused_sel;
  assign unused_sel = ^wb.wb_sel_i;

  assign offset  = wb.wb_adr_i - BASE_ADDR;
  assign in_win  = (offset < WB_DATA'(ELUKS_NUM_REGS));
  assign off_idx = offset[2:0];
  assign req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign wdat    = 32'(wb.wb_dat_i);

  // A done pulse landing on the start pulse belongs to no request of ours.
  assign core_done_ok = core_done && !core_start;

  assign fifo_push  = byte_valid && byte_ready;
  assign fifo_flush = (state == S_IDLE) && req && in_win &&
                      (off_idx == ELUKS_RQ_STATUS) && wb.wb_we_i;
  assign fifo_pop   = !fifo_empty &&
                      (((state == S_IDLE) && req && in_win && (off_idx == ELUKS_RQ_DATA)) ||
                       ((state == S_WAIT_BYTE) && wb.wb_cyc_i));

  eluks_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (wb_clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wr_data ({byte_last, byte_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Decode of a request seen in IDLE: next state and the word to return
  // if it is acknowledged immediately.
  always_comb begin
    idle_next = S_ACK;
    idle_word = '0;
    if (in_win) begin
      case (off_idx)
        ELUKS_PSW_0:       idle_word = WB_DATA'(wb.wb_we_i ? wdat : psw_0);
        ELUKS_PSW_1:       idle_word = WB_DATA'(wb.wb_we_i ? wdat : psw_1);
        ELUKS_START_BLOCK: idle_word = WB_DATA'(wb.wb_we_i ? wdat : start_block_q);
        ELUKS_BLOCK_DIR:   idle_word = WB_DATA'(wb.wb_we_i ? wdat : block_dir_q);
        ELUKS_HMAC_ENABLE: idle_word = WB_DATA'(wb.wb_we_i ? wdat : hmac_q);
        ELUKS_RQ_DATA: begin
          if (!fifo_empty)   idle_word = WB_DATA'(fifo_rd[7:0]);
          else if (!drained) idle_next = S_WAIT_BYTE;
        end
        ELUKS_RQ_STATUS: begin
          if (wb.wb_we_i) idle_next = S_WAIT_CORE;
          else            idle_word = WB_DATA'(status);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state         <= S_IDLE;
      psw_0         <= '0;
      psw_1         <= '0;
      start_block_q <= '0;
      block_dir_q   <= '0;
      hmac_q        <= '0;
      status        <= '0;
      drained       <= 1'b0;
      dat_o         <= '0;
      core_start    <= 1'b0;
    end else begin
      core_start <= 1'b0;

      // Status is latched even when the master has abandoned the request.
      if (core_done_ok) status <= pack_status(core_error, core_total_blocks);

      if (fifo_flush)                drained <= 1'b0;
      else if (fifo_pop && fifo_rd[8]) drained <= 1'b1;

      case (state)
        S_IDLE: begin
          if (req) begin
            state <= idle_next;
            if (idle_next == S_ACK) dat_o <= idle_word;
            if (fifo_flush) core_start <= 1'b1;
            if (in_win && wb.wb_we_i) begin
              case (off_idx)
                ELUKS_PSW_0:       psw_0         <= wdat;
                ELUKS_PSW_1:       psw_1         <= wdat;
                ELUKS_START_BLOCK: start_block_q <= wdat;
                ELUKS_BLOCK_DIR:   block_dir_q   <= wdat;
                ELUKS_HMAC_ENABLE: hmac_q        <= wdat;
                default: ;
              endcase
            end
          end
        end
        S_ACK: state <= S_RELEASE;
        S_WAIT_CORE: begin
          if (!wb.wb_cyc_i) begin
            state <= S_IDLE;
          end else if (core_done_ok) begin
            dat_o <= WB_DATA'(pack_status(core_error, core_total_blocks));
            state <= S_ACK;
          end
        end
        S_WAIT_BYTE: begin
          if (!wb.wb_cyc_i) begin
            state <= S_IDLE;
          end else if (!fifo_empty) begin
            dat_o <= WB_DATA'(fifo_rd[7:0]);
            state <= S_ACK;
          end else if (drained) begin
            dat_o <= '0;
            state <= S_ACK;
          end
        end
        S_RELEASE: if (!req) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign wb.wb_ack_o = (state == S_ACK);
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_dat_o = dat_o;

  assign psw         = {psw_0, psw_1};
  assign start_block = start_block_q;
  assign block_dir   = block_dir_q;
  assign hmac_enable = hmac_q[0];
  assign byte_ready  = !fifo_full;
  assign dbg_state   = state;

endmodule

// File: tb/tb_eluks_wb_slave.sv
// tb_eluks_wb_slave: directed self-checking bench for eluks_wb_slave.
module tb_eluks_wb_slave;
  import eluks_pkg::*;

  localparam logic [31:0] BASE = 32'h9200_0000;

  // ---------------- clock / reset ----------------
  logic wb_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 wb_clk = ~wb_clk;

  logic [63:0]  psw;
  logic [31:0]  start_block, block_dir;
  logic         hmac_enable, core_start;
  logic         core_done = 1'b0, core_error = 1'b0;
  logic [30:0]  core_total_blocks = '0;
  logic         byte_valid = 1'b0, byte_last = 1'b0;
  logic [7:0]   byte_data = '0;
  logic         byte_ready;
  eluks_state_t dbg_state;

  eluks_wb_slave_if #(.WB_DATA(32)) wbif ();

  eluks_wb_slave #(.WB_DATA(32), .BASE_ADDR(BASE), .FIFO_DEPTH(16)) dut (
    .wb_clk            (wb_clk),
    .rst               (rst),
    .wb                (wbif),
    .psw               (psw),
    .start_block       (start_block),
    .block_dir         (block_dir),
    .hmac_enable       (hmac_enable),
    .core_start        (core_start),
    .core_done         (core_done),
    .core_error        (core_error),
    .core_total_blocks (core_total_blocks),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_last         (byte_last),
    .byte_ready        (byte_ready),
    .dbg_state         (dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;
  int start_cnt = 0;

  always @(negedge wb_clk) if (core_start) start_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (call at posedge+1) ----------------
  task automatic wb_access(input logic we, input logic [31:0] off, input logic [31:0] wdata,
                           input int max_cyc, output logic [31:0] rdata, output int lat,
                           output logic acked, output logic ack_extra);
    lat = 0; acked = 1'b0; rdata = '0; ack_extra = 1'b0;
    wbif.wb_adr_i = BASE + off;
    wbif.wb_dat_i = wdata;
    wbif.wb_sel_i = 4'hF;
    wbif.wb_we_i  = we;
    wbif.wb_cyc_i = 1'b1;
    wbif.wb_stb_i = 1'b1;
    while (!acked && lat < max_cyc) begin
      @(posedge wb_clk); #1;
      lat++;
      if (wbif.wb_ack_o) begin
        acked = 1'b1;
        rdata = wbif.wb_dat_o;
      end
    end
    wbif.wb_cyc_i = 1'b0;
    wbif.wb_stb_i = 1'b0;
    wbif.wb_we_i  = 1'b0;
    @(posedge wb_clk); #1;
    ack_extra = wbif.wb_ack_o;
    @(posedge wb_clk); #1;
  endtask

  task automatic pulse_done(input logic err, input logic [30:0] total);
    core_error        = err;
    core_total_blocks = total;
    core_done         = 1'b1;
    @(posedge wb_clk); #1;
    core_done = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    int guard = 0;
    while (!byte_ready && guard < 50) begin
      @(posedge wb_clk); #1;
      guard++;
    end
    check("push_ready", byte_ready, 1'b1);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    @(posedge wb_clk); #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  int          lat;
  logic        acked, extra;
  logic [7:0]  fill_b;

  initial begin
    wbif.wb_adr_i = '0; wbif.wb_dat_i = '0; wbif.wb_sel_i = '0;
    wbif.wb_we_i = 1'b0; wbif.wb_cyc_i = 1'b0; wbif.wb_stb_i = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    // reset state
    check("rst_ack",   wbif.wb_ack_o, 1'b0);
    check("rst_err",   wbif.wb_err_o, 1'b0);
    check("rst_dat",   wbif.wb_dat_o, 32'h0);
    check("rst_psw",   psw, 64'h0);
    check("rst_sblk",  start_block, 32'h0);
    check("rst_start", core_start, 1'b0);
    check("rst_ready", byte_ready, 1'b1);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    @(posedge wb_clk); #1;

    // register writes / reads
    wb_access(1'b1, 32'd0, 32'hDEADBEEF, 10, rd, lat, acked, extra);
    check("psw0_wr_ack", acked, 1'b1);
    check("psw0_wr_lat", lat, 1);
    check("psw0_wr_single", extra, 1'b0);
    wb_access(1'b1, 32'd1, 32'h01234567, 10, rd, lat, acked, extra);
    check("psw1_wr_lat", lat, 1);
    check("psw1_wr_single", extra, 1'b0);
    check("psw_value", psw, 64'hDEADBEEF01234567);
    wb_access(1'b0, 32'd0, 32'h0, 10, rd, lat, acked, extra);
    check("psw0_rd", rd, 32'hDEADBEEF);
    check("psw0_rd_lat", lat, 1);
    wb_access(1'b1, 32'd2, 32'h00000010, 10, rd, lat, acked, extra);
    wb_access(1'b1, 32'd3, 32'h00000001, 10, rd, lat, acked, extra);
    wb_access(1'b1, 32'd4, 32'h00000003, 10, rd, lat, acked, extra);
    check("start_block", start_block, 32'h10);
    check("block_dir",   block_dir, 32'h1);
    check("hmac_enable", hmac_enable, 1'b1);
    wb_access(1'b0, 32'd4, 32'h0, 10, rd, lat, acked, extra);
    check("hmac_rd", rd, 32'h3);
    wb_access(1'b1, 32'd7, 32'hFFFFFFFF, 10, rd, lat, acked, extra);
    check("off7_wr_ack", acked, 1'b1);
    wb_access(1'b0, 32'd7, 32'h0, 10, rd, lat, acked, extra);
    check("off7_rd_ack", acked, 1'b1);
    check("off7_rd", rd, 32'h0);
    check("off7_no_side_effect", psw, 64'hDEADBEEF01234567);

    // status request, done 20 cycles later
    fork
      wb_access(1'b1, 32'd6, 32'h0, 60, rd, lat, acked, extra);
      begin repeat (20) @(posedge wb_clk); #1; pulse_done(1'b0, 31'd3); end
    join
    check("stat_ack", acked, 1'b1);
    check("stat_lat", lat, 21);
    check("stat_data", rd, 32'h00000003);
    check("stat_single", extra, 1'b0);
    check("stat_starts", start_cnt, 1);

    // done coinciding with core_start is ignored
    fork
      wb_access(1'b1, 32'd6, 32'h0, 60, rd, lat, acked, extra);
      begin
        @(posedge wb_clk); #1; pulse_done(1'b0, 31'd7);
        repeat (3) @(posedge wb_clk); #1; pulse_done(1'b0, 31'd5);
      end
    join
    check("coinc_lat", lat, 6);
    check("coinc_data", rd, 32'h00000005);

    // error status
    fork
      wb_access(1'b1, 32'd6, 32'h0, 60, rd, lat, acked, extra);
      begin repeat (4) @(posedge wb_clk); #1; pulse_done(1'b1, 31'd0); end
    join
    check("err_lat", lat, 5);
    check("err_data", rd, 32'h80000000);
    wb_access(1'b0, 32'd6, 32'h0, 10, rd, lat, acked, extra);
    check("stat_rd", rd, 32'h80000000);
    check("stat_rd_lat", lat, 1);
    check("stat_rd_nostart", start_cnt, 3);

    // master abandons the status request; result still latched
    wb_access(1'b1, 32'd6, 32'h0, 3, rd, lat, acked, extra);
    check("abandon_noack", acked, 1'b0);
    pulse_done(1'b0, 31'd9);
    wb_access(1'b0, 32'd6, 32'h0, 10, rd, lat, acked, extra);
    check("abandon_latched", rd, 32'h00000009);
    check("abandon_starts", start_cnt, 4);

    // byte stream: three bytes then padding
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b1);
    wb_access(1'b0, 32'd5, 32'h0, 10, rd, lat, acked, extra);
    check("data0", rd, 32'h11);
    check("data0_lat", lat, 1);
    check("data0_single", extra, 1'b0);
    wb_access(1'b1, 32'd5, 32'h0, 10, rd, lat, acked, extra);
    check("data1_we_ignored", rd, 32'h22);
    wb_access(1'b0, 32'd5, 32'h0, 10, rd, lat, acked, extra);
    check("data2", rd, 32'h33);
    wb_access(1'b0, 32'd5, 32'h0, 10, rd, lat, acked, extra);
    check("data_pad_ack", acked, 1'b1);
    check("data_pad", rd, 32'h0);
    check("data_pad_lat", lat, 1);

    // new status request clears drained
    fork
      wb_access(1'b1, 32'd6, 32'h0, 40, rd, lat, acked, extra);
      begin repeat (2) @(posedge wb_clk); #1; pulse_done(1'b0, 31'd1); end
    join
    check("stat2_lat", lat, 3);
    check("stat2_data", rd, 32'h1);

    // empty, not drained: stall until a byte arrives
    fork
      wb_access(1'b0, 32'd5, 32'h0, 40, rd, lat, acked, extra);
      begin repeat (10) @(posedge wb_clk); #1; push_byte(8'hA5, 1'b0); end
    join
    check("stall_ack", acked, 1'b1);
    check("stall_lat", lat, 12);
    check("stall_data", rd, 32'hA5);

    // fill the FIFO
    for (int i = 0; i < 16; i++) begin
      fill_b = 8'h40 + 8'(i);
      push_byte(fill_b, 1'b0);
    end
    check("full_ready", byte_ready, 1'b0);
    wb_access(1'b0, 32'd5, 32'h0, 10, rd, lat, acked, extra);
    check("full_pop", rd, 32'h40);
    check("full_pop_ready", byte_ready, 1'b1);
    push_byte(8'h50, 1'b0);
    check("refill_ready", byte_ready, 1'b0);

    // reset discards FIFO contents and registers
    rst = 1'b1;
    @(posedge wb_clk); #1;
    rst = 1'b0;
    check("rst2_ready", byte_ready, 1'b1);
    check("rst2_psw", psw, 64'h0);
    check("rst2_dat", wbif.wb_dat_o, 32'h0);
    check("rst2_state", dbg_state, S_IDLE);
    @(posedge wb_clk); #1;

    // reset during WAIT_BYTE
    wbif.wb_adr_i = BASE + 32'd5;
    wbif.wb_we_i  = 1'b0;
    wbif.wb_cyc_i = 1'b1;
    wbif.wb_stb_i = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1;
    check("wb_state_wait", dbg_state, S_WAIT_BYTE);
    check("wb_noack", wbif.wb_ack_o, 1'b0);
    rst = 1'b1;
    wbif.wb_cyc_i = 1'b0;
    wbif.wb_stb_i = 1'b0;
    @(posedge wb_clk); #1;
    check("rst3_state", dbg_state, S_IDLE);
    check("rst3_ack", wbif.wb_ack_o, 1'b0);
    check("rst3_dat", wbif.wb_dat_o, 32'h0);
    check("rst3_start", core_start, 1'b0);
    check("rst3_ready", byte_ready, 1'b1);
    rst = 1'b0;
    @(posedge wb_clk); #1;

    wb_access(1'b0, 32'd1, 32'h0, 10, rd, lat, acked, extra);
    check("post_rst_ack", acked, 1'b1);
    check("post_rst_psw1", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
